// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch/commit sequencer and branch unit.
package riscv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT,
        ST_TRAP
    } seq_state_t;

    // Branch-unit operation encodings, shared with the decoder.
    localparam logic [4:0] BR_NONE = 5'b00000;
    localparam logic [4:0] BR_JUMP = 5'b10000;
    localparam logic [4:0] BR_EQ   = 5'b01000;
    localparam logic [4:0] BR_NE   = 5'b01001;
    localparam logic [4:0] BR_LT   = 5'b01100;
    localparam logic [4:0] BR_GE   = 5'b01101;
    localparam logic [4:0] BR_LTU  = 5'b01110;
    localparam logic [4:0] BR_GEU  = 5'b01111;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/perf_counter.sv
// Wrapping event counter; a synchronous clear overrides a same-cycle increment.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer with halt/trap handling and perf counters.
//   state | meaning
//   IDLE  | single settling cycle after reset release
//   FETCH | InstReq high, waiting for InstReady
//   EXEC  | InstOut valid, commit decided at the clock edge
//   HALT  | ecall/ebreak committed, waiting for Resume
//   TRAP  | misaligned branch target, sticky until reset
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             InstReq,
    output logic [XLEN-1:0]  PC,
    input  logic             InstReady,
    input  logic [31:0]      Inst,
    output logic [31:0]      InstOut,
    output logic             InstValid,
    input  logic             NextPCSrc,
    input  logic [XLEN-1:0]  ALURes,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             Resume,
    input  logic             CntClr,
    output logic             Halted,
    output logic             Trap,
    output logic [XLEN-1:0]  TrapPC,
    output logic [CNT_W-1:0] RetireCnt,
    output logic [CNT_W-1:0] BrTakenCnt
);

    localparam logic [XLEN-1:0] LSB_CLR = ~XLEN'(1);

    seq_state_t      r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_trap_pc;
    logic            r_inst_req;
    logic            r_inst_valid;
    logic            r_halted;
    logic            r_trap;

    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_seq;
    logic            w_exec_go;
    logic            w_misaligned;
    logic            w_retire_inc;
    logic            w_br_inc;

    // JALR semantics: bit 0 of the target is always dropped.
    assign w_target     = ALURes & LSB_CLR;
    assign w_pc_seq     = r_pc + XLEN'(PC_STEP);
    assign w_exec_go    = (r_state == ST_EXEC) && !Stall;
    assign w_misaligned = NextPCSrc && w_target[1];

    // Halt outranks branching, so a halting instruction always retires.
    assign w_retire_inc = w_exec_go && (Halt || !w_misaligned);
    assign w_br_inc     = w_exec_go && !Halt && NextPCSrc && !w_target[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_VECTOR;
            r_inst       <= '0;
            r_trap_pc    <= '0;
            r_inst_req   <= 1'b0;
            r_inst_valid <= 1'b0;
            r_halted     <= 1'b0;
            r_trap       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_FETCH;
                    r_inst_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (InstReady) begin
                        r_inst       <= Inst;
                        r_state      <= ST_EXEC;
                        r_inst_req   <= 1'b0;
                        r_inst_valid <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (!Stall) begin
                        r_inst_valid <= 1'b0;
                        if (Halt) begin
                            r_pc     <= w_pc_seq;
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else if (w_misaligned) begin
                            r_trap_pc <= r_pc;
                            r_state   <= ST_TRAP;
                            r_trap    <= 1'b1;
                        end else begin
                            r_pc       <= NextPCSrc ? w_target : w_pc_seq;
                            r_state    <= ST_FETCH;
                            r_inst_req <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (Resume) begin
                        r_state    <= ST_FETCH;
                        r_halted   <= 1'b0;
                        r_inst_req <= 1'b1;
                    end
                end
                ST_TRAP: begin
                    r_state <= ST_TRAP;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_inst_req   <= 1'b0;
                    r_inst_valid <= 1'b0;
                    r_halted     <= 1'b0;
                end
            endcase
        end
    end

    perf_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (CntClr),
        .inc   (w_retire_inc),
        .count (RetireCnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_br_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (CntClr),
        .inc   (w_br_inc),
        .count (BrTakenCnt)
    );

    assign InstReq   = r_inst_req;
    assign PC        = r_pc;
    assign InstOut   = r_inst;
    assign InstValid = r_inst_valid;
    assign Halted    = r_halted;
    assign Trap      = r_trap;
    assign TrapPC    = r_trap_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed table, corner sequences, random run vs instruction-level model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        InstReq;
    logic [31:0] PC;
    logic        InstReady;
    logic [31:0] Inst;
    logic [31:0] InstOut;
    logic        InstValid;
    logic        NextPCSrc;
    logic [31:0] ALURes;
    logic        Stall;
    logic        Halt;
    logic        Resume;
    logic        CntClr;
    logic        Halted;
    logic        Trap;
    logic [31:0] TrapPC;
    logic [31:0] RetireCnt;
    logic [31:0] BrTakenCnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .InstReq    (InstReq),
        .PC         (PC),
        .InstReady  (InstReady),
        .Inst       (Inst),
        .InstOut    (InstOut),
        .InstValid  (InstValid),
        .NextPCSrc  (NextPCSrc),
        .ALURes     (ALURes),
        .Stall      (Stall),
        .Halt       (Halt),
        .Resume     (Resume),
        .CntClr     (CntClr),
        .Halted     (Halted),
        .Trap       (Trap),
        .TrapPC     (TrapPC),
        .RetireCnt  (RetireCnt),
        .BrTakenCnt (BrTakenCnt)
    );

    typedef struct {
        int          lat;
        int          stall;
        logic        halt;
        logic        nps;
        logic [31:0] alu;
        logic        clr;
        logic [31:0] pc;
        logic [31:0] exp_pc;
        logic [31:0] exp_ret;
        logic [31:0] exp_br;
        logic        exp_halt;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_fetch(input int lat, input logic [31:0] word, input logic [31:0] exp_pc);
        int k = 0;
        while (InstReq !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("fetch_req", 32'(InstReq), 32'd1);
        chk("fetch_pc", PC, exp_pc);
        for (int i = 0; i < lat; i++) begin
            InstReady = 1'b0;
            Inst      = $urandom;
            tick();
            chk("wait_req", 32'(InstReq), 32'd1);
            chk("wait_pc", PC, exp_pc);
        end
        InstReady = 1'b1;
        Inst      = word;
        tick();
        InstReady = 1'b0;
        Inst      = $urandom;
        chk("exec_valid", 32'(InstValid), 32'd1);
        chk("exec_inst", InstOut, word);
        chk("exec_req", 32'(InstReq), 32'd0);
    endtask

    task automatic do_exec(input int stall, input logic halt, input logic nps, input logic [31:0] alu,
                           input logic clr, input logic [31:0] exp_pc, input logic [31:0] exp_ret_before);
        Halt      = halt;
        NextPCSrc = nps;
        ALURes    = alu;
        CntClr    = 1'b0;
        for (int i = 0; i < stall; i++) begin
            Stall = 1'b1;
            tick();
            chk("stall_valid", 32'(InstValid), 32'd1);
            chk("stall_pc", PC, exp_pc);
            chk("stall_ret", RetireCnt, exp_ret_before);
            chk("stall_halted", 32'(Halted), 32'd0);
        end
        Stall  = 1'b0;
        CntClr = clr;
        tick();
        Halt      = 1'b0;
        NextPCSrc = 1'b0;
        ALURes    = $urandom;
        CntClr    = 1'b0;
    endtask

    task automatic do_resume(input logic [31:0] exp_pc);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("halt_flag", 32'(Halted), 32'd1);
            chk("halt_req", 32'(InstReq), 32'd0);
            chk("halt_pc", PC, exp_pc);
        end
        Resume = 1'b1;
        tick();
        Resume = 1'b0;
        chk("resume_halted", 32'(Halted), 32'd0);
        chk("resume_req", 32'(InstReq), 32'd1);
        chk("resume_pc", PC, exp_pc);
    endtask

    initial begin
        logic [31:0] m_pc;
        logic [31:0] m_ret;
        logic [31:0] m_br;
        logic [31:0] prev_ret;
        logic [31:0] word;
        logic [31:0] alu;
        logic        halt;
        logic        nps;
        logic        clr;
        int          lat;
        int          stall;

        tv[0] = '{0, 0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'd1, 32'd0, 1'b0};
        tv[1] = '{1, 0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0004, 32'h0000_0008, 32'd2, 32'd0, 1'b0};
        tv[2] = '{0, 0, 1'b0, 1'b1, 32'h0000_0041, 1'b0, 32'h0000_0008, 32'h0000_0040, 32'd3, 32'd1, 1'b0};
        tv[3] = '{5, 0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0040, 32'h0000_0044, 32'd4, 32'd1, 1'b0};
        tv[4] = '{0, 1, 1'b0, 1'b1, 32'h0000_0011, 1'b0, 32'h0000_0044, 32'h0000_0010, 32'd5, 32'd2, 1'b0};
        tv[5] = '{0, 2, 1'b1, 1'b1, 32'h0000_0022, 1'b0, 32'h0000_0010, 32'h0000_0014, 32'd6, 32'd2, 1'b1};
        tv[6] = '{2, 0, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0, 32'h0000_0014, 32'hFFFF_FFFC, 32'd7, 32'd3, 1'b0};
        tv[7] = '{0, 0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'd8, 32'd3, 1'b0};
        tv[8] = '{0, 0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0004, 32'd0, 32'd0, 1'b0};
        tv[9] = '{0, 0, 1'b0, 1'b1, 32'h0000_0101, 1'b0, 32'h0000_0004, 32'h0000_0100, 32'd1, 32'd1, 1'b0};

        rst_n = 1'b1; InstReady = 1'b0; Inst = '0; NextPCSrc = 1'b0; ALURes = '0;
        Stall = 1'b0; Halt = 1'b0; Resume = 1'b0; CntClr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_pc", PC, 32'h0);
        chk("rst_req", 32'(InstReq), 32'd0);
        chk("rst_valid", 32'(InstValid), 32'd0);
        chk("rst_halted", 32'(Halted), 32'd0);
        chk("rst_trap", 32'(Trap), 32'd0);
        chk("rst_instout", InstOut, 32'h0);
        chk("rst_trappc", TrapPC, 32'h0);
        chk("rst_ret", RetireCnt, 32'd0);
        chk("rst_br", BrTakenCnt, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_to_fetch", 32'(InstReq), 32'd1);

        // Directed table
        prev_ret = 32'd0;
        for (int v = 0; v < 10; v++) begin
            do_fetch(tv[v].lat, 32'h1000_0000 + 32'(v), tv[v].pc);
            do_exec(tv[v].stall, tv[v].halt, tv[v].nps, tv[v].alu, tv[v].clr, tv[v].pc, prev_ret);
            chk($sformatf("v%0d_pc", v), PC, tv[v].exp_pc);
            chk($sformatf("v%0d_ret", v), RetireCnt, tv[v].exp_ret);
            chk($sformatf("v%0d_br", v), BrTakenCnt, tv[v].exp_br);
            chk($sformatf("v%0d_halted", v), 32'(Halted), 32'(tv[v].exp_halt));
            if (tv[v].exp_halt) do_resume(tv[v].exp_pc);
            prev_ret = tv[v].exp_ret;
        end

        // Misaligned branch target traps and stays trapped
        do_fetch(0, 32'hDEAD_0001, 32'h0000_0100);
        do_exec(0, 1'b0, 1'b1, 32'h0000_0022, 1'b0, 32'h0000_0100, 32'd1);
        chk("trap_flag", 32'(Trap), 32'd1);
        chk("trap_pc", TrapPC, 32'h0000_0100);
        chk("trap_pc_hold", PC, 32'h0000_0100);
        chk("trap_ret", RetireCnt, 32'd1);
        chk("trap_br", BrTakenCnt, 32'd1);
        InstReady = 1'b1;
        Resume    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("trap_sticky", 32'(Trap), 32'd1);
            chk("trap_req", 32'(InstReq), 32'd0);
            chk("trap_valid", 32'(InstValid), 32'd0);
        end
        Resume = 1'b0;

        // Reset clears trap; InstReady held high through IDLE must not be taken
        rst_n = 1'b0;
        #1;
        chk("trap_rst_flag", 32'(Trap), 32'd0);
        chk("trap_rst_trappc", TrapPC, 32'h0);
        chk("trap_rst_pc", PC, 32'h0);
        Inst = 32'hCAFE_0000;
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_ignore_valid", 32'(InstValid), 32'd0);
        chk("idle_ignore_req", 32'(InstReq), 32'd1);
        tick();
        InstReady = 1'b0;
        chk("zw_valid", 32'(InstValid), 32'd1);
        chk("zw_inst", InstOut, 32'hCAFE_0000);
        do_exec(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'd0);
        chk("zw_pc", PC, 32'h4);
        chk("zw_ret", RetireCnt, 32'd1);

        // Reset mid-FETCH takes effect without waiting for a clock edge
        tick();
        tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_pc", PC, 32'h0);
        chk("midrst_ret", RetireCnt, 32'd0);
        chk("midrst_req", 32'(InstReq), 32'd0);
        tick();
        rst_n = 1'b1;

        // Random run against instruction-level model
        m_pc = 32'h0; m_ret = 32'd0; m_br = 32'd0;
        for (int n = 0; n < 60; n++) begin
            lat   = $urandom_range(0, 3);
            word  = $urandom;
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            halt  = ($urandom_range(0, 7) == 0);
            nps   = 1'($urandom_range(0, 1));
            alu   = $urandom & 32'hFFFF_FFFD;
            clr   = ($urandom_range(0, 9) == 0);
            do_fetch(lat, word, m_pc);
            do_exec(stall, halt, nps, alu, clr, m_pc, m_ret);
            m_ret = m_ret + 1;
            if (halt) begin
                m_pc = m_pc + 4;
            end else if (nps) begin
                m_pc = {alu[31:1], 1'b0};
                m_br = m_br + 1;
            end else begin
                m_pc = m_pc + 4;
            end
            if (clr) begin
                m_ret = 0;
                m_br  = 0;
            end
            chk("rnd_pc", PC, m_pc);
            chk("rnd_ret", RetireCnt, m_ret);
            chk("rnd_br", BrTakenCnt, m_br);
            chk("rnd_halted", 32'(Halted), 32'(halt));
            if (halt) do_resume(m_pc);
        end

        alu = $urandom | 32'h2;
        do_fetch(1, $urandom, m_pc);
        do_exec(0, 1'b0, 1'b1, alu, 1'b0, m_pc, m_ret);
        chk("rnd_trap", 32'(Trap), 32'd1);
        chk("rnd_trappc", TrapPC, m_pc);
        chk("rnd_trap_ret", RetireCnt, m_ret);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the program counter and instruction-fetch sequencing for the RISC-V core.
- Fetches each instruction over a req/ready handshake to instruction memory.
- Presents the instruction to the datapath for one commit cycle, then picks the next PC from BranchUnit's NextPCSrc decision and the ALU-computed target.
- Handles stall, halt/resume and misaligned-target traps.
- Keeps retired-instruction and taken-branch performance counters.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
XLEN, 32, PC/target width
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
InstReq  out  1  fetch request to instruction memory
PC  out  XLEN  current program counter (fetch address)
InstReady  in  1  instruction memory has Inst valid this cycle
Inst  in  32  fetched instruction word
InstOut  out  32  latched instruction to decoder/datapath
InstValid  out  1  InstOut valid; commit cycle
NextPCSrc  in  1  from BranchUnit: 1 = take ALURes target
ALURes  in  XLEN  branch/jump target computed by ALU
Stall  in  1  hold the current commit cycle
Halt  in  1  decoded ecall/ebreak in the current instruction
Resume  in  1  leave HALT state
CntClr  in  1  synchronous clear of both counters
Halted  out  1  in HALT state
Trap  out  1  in TRAP state (sticky until reset)
TrapPC  out  XLEN  PC of the instruction that faulted
RetireCnt  out  CNT_W  committed instructions
BrTakenCnt  out  CNT_W  committed instructions with NextPCSrc=1

Behaviour:
- Reset (async, rst_n=0): state IDLE, PC=RESET_VECTOR, InstOut=0, TrapPC=0, counters=0; all control outputs (InstReq, InstValid, Halted, Trap) =0.
- States: IDLE, FETCH, EXEC, HALT, TRAP.
- IDLE: exactly one cycle after reset release, then FETCH. InstReady is ignored in IDLE.
- FETCH:
  - InstReq=1; PC stable.
  - On InstReady=1: InstOut<=Inst, go to EXEC on the next edge.
  - Zero-wait memory (InstReady already high) gives 2 cycles per instruction: FETCH + EXEC.
- EXEC: InstValid=1; datapath combinationally drives NextPCSrc, ALURes and Halt. Priority at the clock edge:
  1. Stall=1: stay in EXEC, no PC change, no count.
  2. Halt=1:
     - Commit; PC<=PC+4; RetireCnt++; go to HALT.
     - NextPCSrc is ignored and not counted.
  3. NextPCSrc=1:
     - target={ALURes[XLEN-1:1],1'b0} (JALR LSB clear).
     - If target[1]=1: TrapPC<=PC, go to TRAP; PC unchanged; no count.
     - Else: PC<=target, RetireCnt++, BrTakenCnt++, go to FETCH.
  4. Otherwise: PC<=PC+4, RetireCnt++, go to FETCH.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC+4 wraps to 0.
- HALT:
  - Halted=1, InstReq=0.
  - Resume=1 goes to FETCH next edge, using the already-advanced PC.
- TRAP: Trap=1, InstReq=0, InstValid=0. Only reset exits TRAP.
- Counters:
  - Wrap on overflow.
  - CntClr=1 zeroes both counters. If CntClr coincides with a commit, the clear wins (both counters =0).
- Reset asserted mid-FETCH or mid-EXEC aborts immediately: no commit, no count.

Decomposition:
- riscv_pkg:
  - seq_state_t enum.
  - BrOp encodings: BR_NONE=5'b00000, BR_JUMP=5'b10000, BR_EQ=5'b01000, BR_NE=5'b01001, BR_LT=5'b01100, BR_GE=5'b01101, BR_LTU=5'b01110, BR_GEU=5'b01111.
  - PC_STEP=4.
- Sub-module perf_counter (CNT_W, clk, rst_n, clr, inc, count), instantiated twice.

Test Plan:
- Reset, zero-wait memory, NextPCSrc=0, no Stall/Halt → PC follows 0,4,8,…; RetireCnt=3 after 3 EXEC cycles; BrTakenCnt=0.
- At PC=8, NextPCSrc=1, ALURes=32'h41 → PC=32'h40; BrTakenCnt=1; RetireCnt increments.
- NextPCSrc=1, ALURes=32'h22 → Trap=1, TrapPC=old PC, PC unchanged, InstReq=0 thereafter; only rst_n=0 clears.
- Halt=1 at PC=32'h10 → Halted=1, PC=32'h14, RetireCnt+1. Resume pulse → FETCH at 32'h14. Same cycle Stall=1+Halt=1 → stays in EXEC, no commit.
- InstReady held low 5 cycles in FETCH → InstReq stays high, PC stable. rst_n pulsed low mid-FETCH → PC=RESET_VECTOR, counters 0 at once.
- PC preloaded via jump to 32'hFFFF_FFFC, no branch → next PC=0. CntClr together with a commit → both counters read 0.
